// File: rtl/accel_host_if.sv
// accel_host_if: job stream, result beat and accelerator register bus of the host sequencer
interface accel_host_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_norm;
    logic [31:0] out_raw;
    logic [8:0]  out_avg;
    logic [18:0] out_var;
    logic        out_err;
    logic        busy;
    logic [15:0] job_cnt;
    logic [31:0] bus_addr;
    logic        bus_wr_en;
    logic        bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    modport master (
        input  in_valid, in_data, out_ready, bus_rdata,
        output in_ready, out_valid, out_norm, out_raw, out_avg, out_var, out_err,
               busy, job_cnt, bus_addr, bus_wr_en, bus_sel, bus_wdata
    );
    modport slave (
        output in_valid, in_data, out_ready, bus_rdata,
        input  in_ready, out_valid, out_norm, out_raw, out_avg, out_var, out_err,
               busy, job_cnt, bus_addr, bus_wr_en, bus_sel, bus_wdata
    );
endinterface

// File: rtl/accel_host_seq.sv
// accel_host_seq: loads a 7-word job into the convolution accelerator, starts it, polls done and returns the results
module accel_host_seq #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned POLL_MAX  = 16
) (
    input logic         clk,
    input logic         rst,
    accel_host_if.master io
);
    typedef enum logic [2:0] {IDLE, LOAD, GO, POLL, READ, OUT} state_t;
    localparam logic [3:0] CTRL = 4'b1000;
    state_t      state_q, state_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic [1:0]  rcnt_q, rcnt_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [15:0] job_cnt_q, job_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic        out_err_q, out_err_d;
    logic [31:0] norm_q, norm_d;
    logic [31:0] raw_q, raw_d;
    logic [8:0]  avg_q, avg_d;
    logic [18:0] res_var_q, res_var_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic        sel_q, sel_d;
    logic [3:0]  code;
    logic        accept;
    assign io.in_ready  = !rst && (state_q == IDLE || (state_q == LOAD && wcnt_q != 3'd7));
    assign accept       = io.in_valid && io.in_ready;
    assign io.out_valid = out_valid_q;
    assign io.out_err   = out_err_q;
    assign io.out_norm  = norm_q;
    assign io.out_raw   = raw_q;
    assign io.out_avg   = avg_q;
    assign io.out_var   = res_var_q;
    assign io.busy      = state_q != IDLE;
    assign io.job_cnt   = job_cnt_q;
    assign io.bus_addr  = addr_q;
    assign io.bus_wr_en = wr_q;
    assign io.bus_sel   = sel_q;
    assign io.bus_wdata = wdata_q;
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        pcnt_d      = pcnt_q;
        job_cnt_d   = job_cnt_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;
        norm_d      = norm_q;
        raw_d       = raw_q;
        avg_d       = avg_q;
        res_var_d   = res_var_q;
        sel_d       = 1'b0;
        wr_d        = 1'b0;
        wdata_d     = 32'h0;
        code        = 4'h0;
        case (state_q)
            IDLE, LOAD: begin
                if (wcnt_q == 3'd7) begin
                    state_d = GO;
                    sel_d   = 1'b1;
                    wr_d    = 1'b1;
                    code    = CTRL;
                    wdata_d = 32'h1;
                end else if (accept) begin
                    // word index 0..5 maps to codes A..F, the last word (G) to code 0
                    state_d = LOAD;
                    wcnt_d  = wcnt_q + 3'd1;
                    sel_d   = 1'b1;
                    wr_d    = 1'b1;
                    code    = wcnt_q == 3'd6 ? 4'h0 : 4'hA + {1'b0, wcnt_q};
                    wdata_d = io.in_data;
                end
            end
            GO: begin
                state_d = POLL;
                pcnt_d  = 16'h0;
                sel_d   = 1'b1;
                code    = CTRL;
            end
            POLL: begin
                if (io.bus_rdata[31]) begin
                    state_d = READ;
                    rcnt_d  = 2'd0;
                    sel_d   = 1'b1;
                    code    = 4'h1;
                end else if (pcnt_q == 16'(POLL_MAX - 1)) begin
                    state_d     = OUT;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b1;
                    norm_d      = 32'h0;
                    raw_d       = 32'h0;
                    avg_d       = 9'h0;
                    res_var_d   = 19'h0;
                end else begin
                    pcnt_d = pcnt_q + 16'd1;
                    sel_d  = 1'b1;
                    code   = CTRL;
                end
            end
            READ: begin
                norm_d    = rcnt_q == 2'd0 ? io.bus_rdata : norm_q;
                raw_d     = rcnt_q == 2'd1 ? io.bus_rdata : raw_q;
                avg_d     = rcnt_q == 2'd2 ? io.bus_rdata[8:0] : avg_q;
                res_var_d = rcnt_q == 2'd3 ? io.bus_rdata[18:0] : res_var_q;
                rcnt_d    = rcnt_q + 2'd1;
                if (rcnt_q == 2'd3) begin
                    state_d     = OUT;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b0;
                end else begin
                    sel_d = 1'b1;
                    code  = rcnt_q == 2'd0 ? 4'h3 : rcnt_q == 2'd1 ? 4'h5 : 4'h6;
                end
            end
            OUT: begin
                if (io.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_err_d   = 1'b0;
                    job_cnt_d   = job_cnt_q + 16'd1;
                    wcnt_d      = 3'd0;
                end
            end
            default: state_d = IDLE;
        endcase
        addr_d = sel_d ? BASE_ADDR + {26'd0, code, 2'b00} : 32'h0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wcnt_q      <= 3'd0;
            rcnt_q      <= 2'd0;
            pcnt_q      <= 16'h0;
            job_cnt_q   <= 16'h0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            norm_q      <= 32'h0;
            raw_q       <= 32'h0;
            avg_q       <= 9'h0;
            res_var_q   <= 19'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wr_q        <= 1'b0;
            sel_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            pcnt_q      <= pcnt_d;
            job_cnt_q   <= job_cnt_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            norm_q      <= norm_d;
            raw_q       <= raw_d;
            avg_q       <= avg_d;
            res_var_q   <= res_var_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            sel_q       <= sel_d;
        end
    end
endmodule

// File: tb/tb_accel_host_seq.sv
// tb_accel_host_seq: randomized jobs against an accelerator responder, with a scoreboard checking bus traffic and result beats
module tb_accel_host_seq;
    localparam logic [31:0] BA = 32'h0000_4000;
    localparam int PM = 4;
    localparam int NEVER = 99;
    localparam logic [3:0] WCODE [7] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
    typedef struct {
        logic        err;
        logic [31:0] norm;
        logic [31:0] raw;
        logic [8:0]  avg;
        logic [18:0] vr;
        int          polls;
        bit          chk_lat;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    accel_host_if io();
    accel_host_seq #(.BASE_ADDR(BA), .POLL_MAX(PM)) dut (.clk(clk), .rst(rst), .io(io.master));
    exp_t        sb[$];
    logic [63:0] wq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] exp_cnt = 16'h0;
    logic [31:0] r_norm = 0, r_raw = 0, r_avg = 0, r_var = 0;
    int          r_lat = NEVER;
    int          r_dcnt = 0;
    bit          r_started = 1'b0;
    int          bp_left = 0;
    bit          rnd_ready = 1'b0;
    function automatic logic [31:0] raddr(input logic [3:0] c);
        return BA + {26'd0, c, 2'b00};
    endfunction
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // accelerator responder: registers answer by address, done rises r_lat cycles after go
    always_comb begin
        io.bus_rdata = 32'hDEAD_BEEF;
        if (io.bus_addr == raddr(4'h8)) io.bus_rdata = {r_started && r_dcnt >= r_lat, 31'h0};
        else if (io.bus_addr == raddr(4'h1)) io.bus_rdata = r_norm;
        else if (io.bus_addr == raddr(4'h3)) io.bus_rdata = r_raw;
        else if (io.bus_addr == raddr(4'h5)) io.bus_rdata = r_avg;
        else if (io.bus_addr == raddr(4'h6)) io.bus_rdata = r_var;
    end
    always @(negedge clk) begin
        if (io.bus_sel && io.bus_wr_en && io.bus_addr == raddr(4'h8)) begin
            r_started <= 1'b1;
            r_dcnt    <= 0;
        end else if (r_started && r_dcnt < 1000) r_dcnt <= r_dcnt + 1;
    end
    initial begin
        io.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (io.out_valid && bp_left > 0) begin
                io.out_ready = 1'b0;
                bp_left--;
            end else io.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end
    int          cyc = 0, start_cyc = 0, polls = 0;
    bit          acc_prev = 0, ov_prev = 0, or_prev = 0, data_wr;
    logic [108:0] snap;
    exp_t        e;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            acc_prev = 0;
            ov_prev  = 0;
            or_prev  = 0;
        end else begin
            data_wr = io.bus_sel && io.bus_wr_en && io.bus_addr != raddr(4'h8);
            if (acc_prev || data_wr) chk("write_trails_accept", 128'(data_wr), 128'(acc_prev));
            if (io.bus_sel && io.bus_wr_en)
                chk("bus_write", {64'h0, io.bus_addr, io.bus_wdata},
                    wq.size() != 0 ? {64'h0, wq.pop_front()} : {128{1'b1}});
            if (io.bus_sel && io.bus_wr_en && io.bus_addr == raddr(4'h8)) polls = 0;
            if (io.bus_sel && !io.bus_wr_en && io.bus_addr == raddr(4'h8)) polls++;
            if (io.in_valid && io.in_ready && !io.busy) start_cyc = cyc;
            if (ov_prev && !or_prev) chk("valid_held", 128'(io.out_valid), 128'(1));
            if (io.out_valid) begin
                chk("in_ready_in_out", 128'(io.in_ready), 128'(0));
                chk("bus_idle_in_out", {61'h0, io.bus_sel, io.bus_wr_en, io.bus_addr, io.bus_wdata}, 128'(0));
                if (!ov_prev && sb.size() != 0 && sb[0].chk_lat)
                    chk("latency_le16", 128'((cyc - start_cyc) <= 16), 128'(1));
                if (ov_prev && !or_prev)
                    chk("out_stable", 128'({io.out_err, io.out_norm, io.out_raw, io.out_avg, io.out_var, io.job_cnt}),
                        128'(snap));
                snap = {io.out_err, io.out_norm, io.out_raw, io.out_avg, io.out_var, io.job_cnt};
                if (io.out_ready) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got a result beat, expected none at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        chk("out_err", 128'(io.out_err), 128'(e.err));
                        chk("out_norm", 128'(io.out_norm), 128'(e.norm));
                        chk("out_raw", 128'(io.out_raw), 128'(e.raw));
                        chk("out_avg", 128'(io.out_avg), 128'(e.avg));
                        chk("out_var", 128'(io.out_var), 128'(e.vr));
                        chk("ctrl_polls", 128'(polls), 128'(e.polls));
                    end
                    chk("job_cnt", 128'(io.job_cnt), 128'(exp_cnt));
                    exp_cnt = exp_cnt + 16'd1;
                end
            end
            ov_prev  = io.out_valid;
            or_prev  = io.out_ready;
            acc_prev = io.in_valid && io.in_ready;
        end
    end
    task automatic wait_idle();
        for (int t = 0; io.busy || sb.size() != 0; t++) begin
            if (t > 500) begin
                $display("FAIL idle_timeout: busy=%0b pending=%0d", io.busy, sb.size());
                $fatal(1);
            end
            @(posedge clk);
            #1;
        end
    endtask
    task automatic put_word(input logic [31:0] w, input int gap);
        repeat (gap) begin
            io.in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        io.in_valid = 1'b1;
        io.in_data  = w;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (io.in_ready) break;
            if (t > 200) begin
                $display("FAIL in_ready_timeout: in_ready=%0b expected 1", io.in_ready);
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.in_data  = $urandom;
    endtask
    task automatic run_job(input logic [31:0] w[7], input int lat, input bit gaps, input int bp,
                           input bit chk_lat, input logic [31:0] raw);
        exp_t x;
        wait_idle();
        r_lat   = lat;
        r_norm  = $urandom;
        r_raw   = raw;
        r_avg   = $urandom;
        r_var   = $urandom;
        bp_left = bp;
        x.err     = lat > PM;
        x.norm    = x.err ? 32'h0 : r_norm;
        x.raw     = x.err ? 32'h0 : r_raw;
        x.avg     = x.err ? 9'h0 : r_avg[8:0];
        x.vr      = x.err ? 19'h0 : r_var[18:0];
        x.polls   = x.err ? PM : lat;
        x.chk_lat = chk_lat;
        sb.push_back(x);
        for (int i = 0; i < 7; i++) wq.push_back({raddr(WCODE[i]), w[i]});
        wq.push_back({raddr(4'h8), 32'h1});
        for (int i = 0; i < 7; i++) put_word(w[i], gaps ? 1 : 0);
    endtask
    logic [31:0] nom [7] = '{32'h01010101, 32'h02020202, 32'h01010101, 32'h02020202,
                             32'h00010101, 32'h00010101, 32'h00010101};
    logic [31:0] rw [7];
    initial begin
        io.in_valid = 1'b0;
        io.in_data  = 32'h0;
        #3;
        chk("reset_outputs", {io.out_valid, io.out_err, io.busy, io.in_ready, io.bus_sel, io.bus_wr_en,
                              io.bus_addr, io.bus_wdata, io.job_cnt}, 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_job(nom, 2, 0, 0, 1, 32'h06060303);
        run_job(nom, 2, 1, 0, 0, 32'h06060303);
        for (int i = 0; i < 7; i++) rw[i] = $urandom;
        run_job(rw, NEVER, 0, 0, 0, $urandom);
        for (int i = 0; i < 7; i++) rw[i] = $urandom;
        run_job(rw, 3, 0, 10, 0, $urandom);
        for (int i = 0; i < 7; i++) rw[i] = $urandom;
        run_job(rw, NEVER, 0, 0, 0, $urandom);
        for (int t = 0; !(io.bus_sel && !io.bus_wr_en && io.bus_addr == raddr(4'h8)); t++) begin
            if (t > 100) begin
                $display("FAIL poll_wait_timeout: bus_addr=%0h expected %0h", io.bus_addr, raddr(4'h8));
                $fatal(1);
            end
            @(negedge clk);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {io.out_valid, io.out_err, io.busy, io.in_ready, io.bus_sel, io.bus_wr_en,
                                    io.bus_addr, io.bus_wdata, io.job_cnt}, 128'(0));
        sb.delete();
        wq.delete();
        exp_cnt = 16'h0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_job(nom, 2, 0, 0, 1, 32'h06060303);
        rnd_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            for (int i = 0; i < 7; i++) rw[i] = $urandom;
            run_job(rw, $urandom_range(1, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0, $urandom);
        end
        wait_idle();
        chk("job_cnt_idle", 128'(io.job_cnt), 128'(exp_cnt));
        force dut.job_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.job_cnt_q;
        exp_cnt = 16'hFFFF;
        for (int i = 0; i < 7; i++) rw[i] = $urandom;
        run_job(rw, 2, 0, 0, 0, $urandom);
        wait_idle();
        chk("job_cnt_wrap", 128'(io.job_cnt), 128'(16'h0000));
        chk("writes_drained", 128'(wq.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
